disp_scanner: RTL

- Pixel sequencer placed directly upstream of the 16x16 matrix driver. It produces the 8-bit pixel address (row in addr[7:4], column in addr[3:0]) and the per-pixel enable.
- Holds a double-buffered 256-bit frame. The host writes rows into the back buffer and requests a swap. The swap takes effect only at a frame boundary, so a frame is never shown half-updated.

---
 rtl/disp_scanner.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/disp_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scanner
//  Purpose  : Pixel sequencer for a 16x16 matrix driver. Walks the 256 pixel
//             addresses with a BLANK/SHOW timing per pixel and drives the
//             pixel enable from a double-buffered frame. Host writes land in
//             the back buffer; a requested swap is applied at the frame wrap.
//  Options  : DISP_SCANNER_SKIP_DARK_EN - dark pixels take a single cycle
//  Revision : 1.0 - initial release
// ============================================================================
module disp_scanner #(
  parameter int DWELL = 8,   // cycles a pixel is shown, 1..255
  parameter int BLANK = 1    // blank cycles after each address change, 0..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_row,
  input  logic [0:15] wr_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        frame_start,
  output logic [7:0]  addr,
  output logic        enable
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Every pixel starts in BLANK unless blanking is disabled altogether.
  localparam state_t     PIX_FIRST  = (BLANK == 0) ? ST_SHOW : ST_BLANK;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LAST = (BLANK == 0) ? 8'd0 : 8'(BLANK - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  addr_q, addr_d;
  logic        enable_q, enable_d;
  logic        frame_start_q, frame_start_d;
  logic        swap_ack_q, swap_ack_d;
  logic        swap_pending_q, swap_pending_d;
  logic [0:15] front_q [16];
  logic [0:15] front_d [16];
  logic [0:15] back_q  [16];
  logic [0:15] back_d  [16];

  logic        pix_last;
  logic        wrap;
  logic        do_swap;
  logic        skip_dark;

`ifdef DISP_SCANNER_SKIP_DARK_EN
  logic pix_first;
  logic cur_lit;
  // A dark pixel is abandoned in its very first cycle.
  assign pix_first = (state_q == PIX_FIRST) && (phase_q == 8'd0);
  assign cur_lit   = front_q[addr_q[7:4]][addr_q[3:0]];
  assign skip_dark = pix_first && !cur_lit;
`else
  assign skip_dark = 1'b0;
`endif

  // Next-state logic: pixel timing, frame wrap, swap handshake and buffers.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    addr_d         = addr_q;
    swap_pending_d = swap_pending_q;
    front_d        = front_q;
    back_d         = back_q;
    pix_last       = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (phase_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ST_SHOW: begin
        if (phase_q == DWELL_LAST) begin
          pix_last = 1'b1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: begin
        state_d = PIX_FIRST;
        phase_d = 8'd0;
      end
    endcase

    if (skip_dark) begin
      pix_last = 1'b1;
    end

    if (pix_last) begin
      addr_d  = addr_q + 8'd1;
      state_d = PIX_FIRST;
      phase_d = 8'd0;
    end

    wrap    = pix_last && (addr_q == 8'hFF);
    do_swap = wrap && (swap_pending_q || swap_req);

    if (wrap) begin
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end

    // The copy takes the back buffer as it was before any same-cycle write.
    if (do_swap) begin
      front_d = back_q;
    end
    if (wr_en) begin
      back_d[wr_row] = wr_data;
    end

    // Outputs are registered, so they are derived from the next state.
    enable_d      = (state_d == ST_SHOW) && front_d[addr_d[7:4]][addr_d[3:0]];
    frame_start_d = wrap;
    swap_ack_d    = do_swap;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= PIX_FIRST;
      phase_q        <= 8'd0;
      addr_q         <= 8'd0;
      enable_q       <= 1'b0;
      frame_start_q  <= 1'b0;
      swap_ack_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      front_q        <= '{default: '0};
      back_q         <= '{default: '0};
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      addr_q         <= addr_d;
      enable_q       <= enable_d;
      frame_start_q  <= frame_start_d;
      swap_ack_q     <= swap_ack_d;
      swap_pending_q <= swap_pending_d;
      front_q        <= front_d;
      back_q         <= back_d;
    end
  end

  assign addr        = addr_q;
  assign enable      = enable_q;
  assign frame_start = frame_start_q;
  assign swap_ack    = swap_ack_q;

endmodule
`default_nettype wire
